// File: rtl/cic_integ_dump_ctrl.sv
// Integrate-and-dump sequencer around a DSP48 accumulator slice.
// Feeds samples and clear slots to the DSP and dumps every M-sample window sum.
module cic_integ_dump_ctrl #(
    parameter int IW      = 5,
    parameter int M       = 256,
    parameter int OW      = 16,
    parameter int SHIFT   = 0,
    parameter int DSP_LAT = 4,
    parameter int OP_SKEW = 1
) (
    input  logic          clk,
    input  logic          sync_reset,
    input  logic          s_axis_tvalid,
    input  logic [IW-1:0] s_axis_tdata,
    output logic          s_axis_tready,
    output logic [47:0]   concat,
    output logic          opcode,
    input  logic [47:0]   p,
    output logic          m_axis_tvalid,
    output logic [OW-1:0] m_axis_tdata,
    input  logic          m_axis_tready
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        CLEAR
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               slot_clr;
    logic [DSP_LAT-1:0] cap_sr;
    logic               last;
    logic               hold_full;
    logic               accept;
    logic               push;
    logic               capture;
    logic               unused_p;

    assign last          = (count == LAST);
    assign hold_full     = m_axis_tvalid && !m_axis_tready;
    assign s_axis_tready = (state == RUN) && !(last && hold_full);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign push          = accept && last;
    assign capture       = cap_sr[DSP_LAT-1];
    assign unused_p      = ^p;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state    <= INIT;
            count    <= '0;
            concat   <= '0;
            slot_clr <= 1'b0;
        end else begin
            concat   <= '0;
            slot_clr <= 1'b0;
            unique case (state)
                INIT: begin
                    slot_clr <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        concat <= {{(48-IW){s_axis_tdata[IW-1]}}, s_axis_tdata};
                        if (last) begin
                            count <= '0;
                            state <= CLEAR;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                CLEAR: begin
                    slot_clr <= 1'b1;
                    state    <= RUN;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Opcode trails its concat word so both meet in the DSP ALU together.
    generate
        if (OP_SKEW == 0) begin : g_no_skew
            assign opcode = slot_clr;
        end else begin : g_skew
            logic [OP_SKEW-1:0] op_sr;
            always_ff @(posedge clk) begin
                if (sync_reset) begin
                    op_sr <= '0;
                end else begin
                    op_sr[0] <= slot_clr;
                    for (int i = 1; i < OP_SKEW; i++) begin
                        op_sr[i] <= op_sr[i-1];
                    end
                end
            end
            assign opcode = op_sr[OP_SKEW-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            cap_sr <= '0;
        end else begin
            cap_sr[0] <= push;
            for (int i = 1; i < DSP_LAT; i++) begin
                cap_sr[i] <= cap_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (capture) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= p[SHIFT+OW-1:SHIFT];
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: doc/cic_integ_dump_ctrl.md
Name: cic_integ_dump_ctrl

Overview:
- Sequencer that sits directly upstream and downstream of the DSP48 integrator slice (the `concat`/`opcode`/`p` block, where opcode 0 gives P = P + A:B and opcode 1 gives P = 0).
- Accepts a signed AXI-Stream sample stream, sign-extends each sample onto the 48-bit `concat` bus, and issues clear slots.
- After every M accepted samples it captures the window sum from `p` and presents it on an AXI-Stream master. The result is an integrate-and-dump (N=1, R=1 CIC decimate-by-M) stage.

Parameters:
- IW, 5, input sample width (signed)
- M, 256, samples per dump window; legal range 8..65536
- OW, 16, output width; the sum is taken from p[SHIFT+OW-1:SHIFT]
- SHIFT, 0, LSB position of the output slice; SHIFT+OW <= 48
- DSP_LAT, 4, cycles from `concat` driven to result visible on `p`
- OP_SKEW, 1, cycles by which `opcode` trails the `concat` word it applies to

Ports:
- clk  in  1  clock
- sync_reset  in  1  synchronous, active-high reset
- s_axis_tvalid  in  1  input sample valid
- s_axis_tdata  in  IW  signed input sample
- s_axis_tready  out  1  input ready
- concat  out  48  to DSP: sign-extended sample, or 0 on clear/idle slots
- opcode  out  1  to DSP: 0 = accumulate, 1 = clear; registered, skewed by OP_SKEW
- p  in  48  from DSP: accumulator value
- m_axis_tvalid  out  1  dump valid
- m_axis_tdata  out  OW  dump value p[SHIFT+OW-1:SHIFT]
- m_axis_tready  in  1  downstream ready

Behaviour:
- **Reset and state machine.** States are INIT, RUN and CLEAR. `sync_reset` forces:
  - state = INIT, window count = 0
  - capture-tracking shift register cleared
  - m_axis_tvalid = 0, m_axis_tdata = 0
  - concat = 0, opcode = 0, s_axis_tready = 0
- **INIT.** Lasts one cycle. Drives a clear slot (concat = 0, with opcode = 1 issued OP_SKEW cycles later), then goes to RUN.
- **RUN.**
  - s_axis_tready = 1, except when count == M-1 and the output holding register is full (m_axis_tvalid = 1 and m_axis_tready = 0).
  - On accept: concat = sign-extended tdata, the matching opcode is 0, and count increments.
  - Cycles with no accept drive concat = 0 with opcode 0 (P holds).
  - When the accepted sample has count == M-1: set count = 0, push a capture token, and go to CLEAR.
- **CLEAR.** Lasts exactly one cycle with s_axis_tready = 0. Drives a clear slot, then returns to RUN.
- **Opcode timing.** The opcode for the slot driven in cycle t is presented at cycle t+OP_SKEW. A 1-bit delay line does this, so accumulate and clear slots land in the DSP ALU in program order.
- **Capture.**
  - The token travels a DSP_LAT-deep shift register.
  - On exit, the holding register loads p[SHIFT+OW-1:SHIFT] and m_axis_tvalid goes to 1.
  - m_axis_tvalid clears on handshake, unless a new capture occurs in the same cycle, in which case the new value loads and valid stays 1.
- **Overflow.** Cannot occur: the last sample of a window is only accepted when the holding register is empty or draining, and M >= 8 > DSP_LAT.
- **Throughput.** M samples per M+1 cycles at sustained input.
- **Latency.** Last sample accepted at cycle t gives m_axis_tvalid at t+DSP_LAT+1.
- **Arithmetic.** Two's complement, no saturation. Bits above SHIFT+OW are discarded (wrap). Full growth is IW+log2(M) bits; with the defaults this is 13 bits and fits within OW.
- **Reset mid-window.** The partial sum is discarded, in-flight tokens are dropped, no output is produced, and the INIT clear re-zeroes P.

Test Plan:
- **Ramp window.** M=8, continuous inputs 1..8 → single output 36, asserted 5 cycles after the 8th accept; s_axis_tready low for exactly 1 cycle after the 8th accept.
- **Negative full scale.** M=8, sixteen samples of -16 → two outputs of -128 (0xFF80 at OW=16); the second window starts from 0, not from -128.
- **Output backpressure.** M=8, m_axis_tready held 0 → first dump held stable; s_axis_tready drops when count = 7; nothing is lost. Release → second dump = correct sum.
- **Sparse input.** tvalid toggling 50% with values alternating +3/-1 → outputs of 8 per window; idle cycles do not change the sum.
- **Reset mid-window.** Reset after 5 of 8 samples, then feed 1..8 → first output 36, with no stale output.
- **Slicing.** M=256, SHIFT=4, OW=8, all inputs 15 → p = 3840 → output 240 (0xF0).
